// File: rtl/bip_pkg.sv
// bip_pkg: shared widths, the HLT opcode and the program-loader state encoding
// used by the BIP I datapath blocks.
package bip_pkg;

  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 16;

  localparam logic [DATA_WIDTH-1:0] HLT_WORD = 16'h0000;

  typedef enum logic [1:0] {
    LOAD_HI,
    LOAD_LO,
    RUN
  } load_state_e;

endpackage

// File: rtl/prog_mem_ram.sv
// prog_mem_ram: DEPTH x DATA_WIDTH synchronous RAM, one write port and one
// registered read port, both on the rising edge of clk_i.
module prog_mem_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: the array and its read register have no reset so the tools can map
  // them onto block RAM; a reload rewrites the words it needs.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/program_memory.sv
// program_memory: BIP I instruction memory with a byte-serial, big-endian loader
// that holds the CPU off until the program is in. Optional macro: PROG_MEM_CHECKSUM_EN.
module program_memory #(
  parameter int ADDR_WIDTH = bip_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bip_pkg::DATA_WIDTH,
  parameter int DEPTH      = 2048
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Addr,
  output logic [DATA_WIDTH-1:0] Instruction,
  input  logic [7:0]            LdByte,
  input  logic                  LdValid,
  input  logic                  LdLast,
  output logic                  LdReady,
  output logic                  CpuHold,
  output logic                  LdDone,
  output logic                  LdOverflow,
  output logic [ADDR_WIDTH:0]   LdCount,
  output logic [DATA_WIDTH-1:0] Checksum
);

  import bip_pkg::load_state_e;
  import bip_pkg::LOAD_HI;
  import bip_pkg::LOAD_LO;
  import bip_pkg::RUN;
  import bip_pkg::HLT_WORD;

  // DEPTH is always 2**ADDR_WIDTH, so the last word sits at the all-ones address.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  load_state_e           state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [7:0]            hi_q;
  logic [ADDR_WIDTH:0]   ld_count_q;
  logic                  overflow_q;
  logic                  fetch_valid_q;

  logic                  xfer;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  assign LdReady = (state_q != RUN);
  assign xfer    = LdValid & LdReady;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = {LdByte, 8'h00};
    if (xfer && state_q == LOAD_LO) begin
      wr_en   = 1'b1;
      wr_data = {hi_q, LdByte};
    end else if (xfer && state_q == LOAD_HI && LdLast) begin
      wr_en   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= LOAD_HI;
      wr_ptr_q      <= '0;
      hi_q          <= '0;
      ld_count_q    <= '0;
      overflow_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= (state_q == RUN);
      if (wr_en) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        ld_count_q <= ld_count_q + 1'b1;
      end
      if (xfer) begin
        unique case (state_q)
          LOAD_HI: begin
            hi_q    <= LdByte;
            state_q <= LdLast ? RUN : LOAD_LO;
          end
          LOAD_LO: begin
            if (LdLast) begin
              state_q <= RUN;
            end else if (wr_ptr_q == LAST_ADDR) begin
              state_q    <= RUN;
              overflow_q <= 1'b1;
            end else begin
              state_q <= LOAD_HI;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  prog_mem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk_i    (Clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(wr_data),
    .rd_en_i  (state_q == RUN),
    .rd_addr_i(Addr),
    .rd_data_o(rd_data)
  );

  // Fetches are only trusted once the read port has sampled during RUN.
  assign Instruction = fetch_valid_q ? rd_data : HLT_WORD;
  assign CpuHold     = LdReady;
  assign LdDone      = (state_q == RUN);
  assign LdOverflow  = overflow_q;
  assign LdCount     = ld_count_q;

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;
  logic [DATA_WIDTH-1:0] checksum_d;

  assign checksum_d = wr_en ? (checksum_q ^ wr_data) : checksum_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign Checksum = checksum_q;
`else
  assign Checksum = '0;
`endif

endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: drives byte-serial loads (directed and $urandom) into
// program_memory and checks status and fetches against a list-based model.
module tb_program_memory;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 2048;

`ifdef PROG_MEM_CHECKSUM_EN
  localparam logic [DW-1:0] DIR_CSUM = 16'h2803;
`else
  localparam logic [DW-1:0] DIR_CSUM = 16'h0000;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic          Clk = 1'b0;
  logic          Reset;
  logic [AW-1:0] Addr;
  logic [DW-1:0] Instruction;
  logic [7:0]    LdByte;
  logic          LdValid;
  logic          LdLast;
  logic          LdReady;
  logic          CpuHold;
  logic          LdDone;
  logic          LdOverflow;
  logic [AW:0]   LdCount;
  logic [DW-1:0] Checksum;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_csum;
  int            exp_count;
  bit            exp_ovf;

  always #5 Clk = ~Clk;

  program_memory dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Addr       (Addr),
    .Instruction(Instruction),
    .LdByte     (LdByte),
    .LdValid    (LdValid),
    .LdLast     (LdLast),
    .LdReady    (LdReady),
    .CpuHold    (CpuHold),
    .LdDone     (LdDone),
    .LdOverflow (LdOverflow),
    .LdCount    (LdCount),
    .Checksum   (Checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected memory image and status for a whole load, from the byte list.
  task automatic model_load(input byte_q_t q, input bit last);
    int n;
    int taken;
    n         = q.size();
    taken     = (n > 2*DEPTH) ? 2*DEPTH : n;
    exp_count = (taken + 1) / 2;
    exp_csum  = '0;
    for (int i = 0; i < exp_count; i++) begin
      logic [7:0] lo;
      lo           = (2*i + 1 < taken) ? q[2*i + 1] : 8'h00;
      model_mem[i] = {q[2*i], lo};
`ifdef PROG_MEM_CHECKSUM_EN
      exp_csum     = exp_csum ^ model_mem[i];
`endif
    end
    exp_ovf = (n > 2*DEPTH) || (n == 2*DEPTH && !last);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset   = 1'b1;
    LdValid = 1'b0;
    LdLast  = 1'b0;
    @(negedge Clk);
    Reset   = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_ready",    LdReady,     1);
    check("rst_hold",     CpuHold,     1);
    check("rst_done",     LdDone,      0);
    check("rst_overflow", LdOverflow,  0);
    check("rst_count",    LdCount,     0);
    check("rst_checksum", Checksum,    0);
    check("rst_instr",    Instruction, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit exp_ready, input bit ends);
    if ($urandom_range(0, 3) == 0) begin
      // Idle cycle with a stray LdLast that must be ignored.
      @(negedge Clk);
      LdValid = 1'b0;
      LdLast  = 1'($urandom_range(0, 1));
      LdByte  = 8'($urandom);
    end
    @(negedge Clk);
    check("ld_ready_pre", LdReady, exp_ready);
    LdValid = 1'b1;
    LdByte  = b;
    LdLast  = last;
    Addr    = AW'($urandom);
    @(posedge Clk);
    #1;
    if (exp_ready) begin
      check("hold_after_byte", CpuHold, !ends);
      check("instr_hlt_loading", Instruction, 16'h0000);
    end
  endtask

  task automatic run_load(input byte_q_t q, input bit last);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      send_byte(q[i], last && (i == n - 1), i < 2*DEPTH,
                (last && (i == n - 1)) || (i == 2*DEPTH - 1));
    end
    @(negedge Clk);
    LdValid = 1'b0;
    LdLast  = 1'b0;
    model_load(q, last);
    @(negedge Clk);
    check("ld_count",    LdCount,    exp_count);
    check("ld_done",     LdDone,     1);
    check("cpu_hold",    CpuHold,    0);
    check("ld_ready",    LdReady,    0);
    check("ld_overflow", LdOverflow, exp_ovf);
    check("checksum",    Checksum,   exp_csum);
  endtask

  task automatic check_fetch(input int k);
    for (int j = 0; j < k + 2; j++) begin
      int a;
      a = (j == 0) ? 0 : (j == 1) ? exp_count - 1 : int'($urandom_range(0, exp_count - 1));
      @(negedge Clk);
      Addr = a[AW-1:0];
      @(posedge Clk);
      #1;
      check($sformatf("fetch[%0d]", a), Instruction, model_mem[a]);
    end
  endtask

  initial begin
    byte_q_t q;
    int      len;

    Reset   = 1'b1;
    Addr    = '0;
    LdByte  = '0;
    LdValid = 1'b0;
    LdLast  = 1'b0;
    do_reset();
    Addr = AW'($urandom);
    check_reset_state();

    // Directed: two words, LdLast on the low byte.
    q = {8'h20, 8'h01, 8'h08, 8'h02};
    run_load(q, 1'b1);
    check("dir_checksum", Checksum, DIR_CSUM);
    check_fetch(4);

    // Odd length: the last high byte is zero-padded.
    do_reset();
    check_reset_state();
    q = {8'hAA, 8'hBB, 8'hCC};
    run_load(q, 1'b1);
    check_fetch(2);

    // Reset after a lone high byte discards it.
    do_reset();
    send_byte(8'h12, 1'b0, 1'b1, 1'b0);
    do_reset();
    check("rst_mid_count", LdCount, 0);
    q = {8'h34, 8'h56};
    run_load(q, 1'b1);
    check_fetch(1);

    // Random programs of random length, odd and even.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      len = int'($urandom_range(1, 60));
      q   = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      run_load(q, 1'b1);
      check_fetch(6);
    end

    // Fill the memory; the 4097th byte carries LdLast and must be refused.
    do_reset();
    q = {};
    for (int i = 0; i < 2*DEPTH + 1; i++) q.push_back(8'($urandom));
    run_load(q, 1'b1);
    check_fetch(8);

    // Reset from RUN returns to loading with HLT on the fetch port.
    do_reset();
    Addr = AW'($urandom);
    check_reset_state();
    @(negedge Clk);
    check("instr_after_run_reset", Instruction, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
